fifo_spram_writer: RTL and testbench

- Drains the ADC sample FIFO and writes the samples, one by one, into a bank of single-port RAMs (SPRAM) as one linear capture buffer.
- Sits between the FIFO's read side (rd_en / data_out / empty) and the multi-SPRAM storage.
- Runs one capture of capture_len samples per start pulse, then signals done.
- Paces its reads so that the FIFO's registered, one-cycle-late empty flag can never cause a read from an empty FIFO.

---
 rtl/fifo_spram_writer_pkg.sv | 19 +
 rtl/spram_bank_decode.sv | 25 ++
 rtl/fifo_spram_writer.sv | 152 +++++++++++++++
 tb/tb_fifo_spram_writer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_spram_writer_pkg.sv
// fifo_spram_writer_pkg: FSM encoding and default geometry shared by the FIFO-to-SPRAM writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_spram_writer_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_ADDR_WIDTH     = 14;
  localparam int DEF_BANK_SEL_WIDTH = 2;
  localparam int DEF_NUM_BANKS      = 1 << DEF_BANK_SEL_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spram_bank_decode.sv
// spram_bank_decode: turns bank-select bits plus the write strobe into a one-hot SPRAM write enable.
// Latency: combinational.
// Backpressure: none; the enable is all-zero whenever the strobe is low.
module spram_bank_decode
  import fifo_spram_writer_pkg::*;
#(
  parameter int BANK_SEL_WIDTH = DEF_BANK_SEL_WIDTH,
  parameter int NUM_BANKS      = DEF_NUM_BANKS
) (
  input  logic [BANK_SEL_WIDTH-1:0] bank,
  input  logic                      wr_stb,
  output logic [NUM_BANKS-1:0]      ram_we
);

  // Compare against each bank index so an out-of-range select can never index past the vector.
  always_comb begin
    ram_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_stb && (bank == BANK_SEL_WIDTH'(b))) begin
        ram_we[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_spram_writer.sv
// fifo_spram_writer: drains the ADC sample FIFO into a bank of SPRAMs as one linear capture buffer.
// Latency: 3 cycles per sample (REQ -> WAIT -> WRITE); at most one sample every 3 cycles.
// Backpressure: stalls in REQ while fifo_empty is high; read pulses are spaced so the lagging empty flag is safe.
// Optional build macro RAM_WR_WRAP_EN: circular capture that wraps at capture_len and ends on a stop pulse.
module fifo_spram_writer
  import fifo_spram_writer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int BANK_SEL_WIDTH = DEF_BANK_SEL_WIDTH,
  parameter int NUM_BANKS      = DEF_NUM_BANKS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic [ADDR_WIDTH+BANK_SEL_WIDTH-1:0] capture_len,
  input  logic                               fifo_empty,
  output logic                               fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]              fifo_data,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  output logic [DATA_WIDTH-1:0]              ram_wdata,
  output logic [NUM_BANKS-1:0]               ram_we,
  output logic                               busy,
  output logic                               done,
  output logic [ADDR_WIDTH+BANK_SEL_WIDTH-1:0] samples_written
);

  localparam int PTR_W = ADDR_WIDTH + BANK_SEL_WIDTH;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       len_q, len_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   rd_en;
  logic                   wr_stb;
  logic                   stop_now;

`ifdef RAM_WR_WRAP_EN
  logic stop_pend_q, stop_pend_d;

  // A stop seen while a capture is running is held until the FSM can act on it.
  always_comb begin
    stop_pend_d = stop_pend_q | stop;
    if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      stop_pend_d = 1'b0;
    end
  end

  // Pending-stop register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_pend_q <= 1'b0;
    end else begin
      stop_pend_q <= stop_pend_d;
    end
  end

  assign stop_now = stop_pend_q | stop;
`else
  logic stop_unused;
  assign stop_unused = stop;
  assign stop_now    = 1'b0;
`endif

  // Next-state, pointer/count update and strobes for the REQ/WAIT/WRITE pacing loop.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rd_en   = 1'b0;
    wr_stb  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = capture_len;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = (capture_len == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (stop_now) begin
          state_d = ST_DONE;
        end else if (!fifo_empty) begin
          rd_en   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wdata_d = fifo_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_stb = 1'b1;
`ifdef RAM_WR_WRAP_EN
        ptr_d   = ((ptr_q + PTR_ONE) == len_q) ? '0 : (ptr_q + PTR_ONE);
        cnt_d   = (cnt_q == len_q) ? cnt_q : (cnt_q + PTR_ONE);
        state_d = stop_now ? ST_DONE : ST_REQ;
`else
        ptr_d   = ptr_q + PTR_ONE;
        cnt_d   = cnt_q + PTR_ONE;
        state_d = ((cnt_q + PTR_ONE) == len_q) ? ST_DONE : ST_REQ;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
    end
  end

  spram_bank_decode #(
    .BANK_SEL_WIDTH (BANK_SEL_WIDTH),
    .NUM_BANKS      (NUM_BANKS)
  ) u_bank_decode (
    .bank   (ptr_q[PTR_W-1:ADDR_WIDTH]),
    .wr_stb (wr_stb),
    .ram_we (ram_we)
  );

  assign fifo_rd_en      = rd_en;
  assign ram_addr        = ptr_q[ADDR_WIDTH-1:0];
  assign ram_wdata       = wdata_q;
  assign busy            = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign done            = (state_q == ST_DONE);
  assign samples_written = cnt_q;

endmodule

// File: tb/tb_fifo_spram_writer.sv
// tb_fifo_spram_writer: directed bench for fifo_spram_writer with a FIFO model whose empty flag lags its count.
// Latency: n/a.
// Backpressure: the FIFO model starves or feeds the writer per scenario.
module tb_fifo_spram_writer;

  localparam int DW = 16;
  localparam int AW = 14;
  localparam int BW = 2;
  localparam int NB = 4;
  localparam int PW = AW + BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PW-1:0] capture_len = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [NB-1:0] ram_we;
  logic          busy;
  logic          done;
  logic [PW-1:0] samples_written;

  always #5 clk = ~clk;

  fifo_spram_writer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .capture_len     (capture_len),
    .fifo_empty      (fifo_empty),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_data       (fifo_data),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .busy            (busy),
    .done            (done),
    .samples_written (samples_written)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] fq[$];
  bit            auto_feed = 1'b0;
  logic [DW-1:0] auto_val = '0;

  typedef struct {
    int            bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wlog[$];
  int  rd_gap = 100;

  // FIFO model: data_out registered on read, empty registered from the count before this edge.
  always @(posedge clk) begin : fifo_model
    int sz;
    sz = fq.size();
    if (fifo_rd_en && (sz != 0)) fifo_data <= fq.pop_front();
    fifo_empty <= (sz == 0);
    if (auto_feed && (sz < 4)) begin
      fq.push_back(auto_val);
      auto_val = auto_val + 16'd1;
    end
  end

  // Bus monitor: read safety, read spacing, one-hot write enable, and the write log.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset) begin
      rd_gap = 100;
    end else begin
      if (fifo_rd_en) begin
        n_assert++;
        if (fq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_underflow: rd_en with fifo count %0d, required >0 at %0t", fq.size(), $time);
        end
        n_assert++;
        if (rd_gap < 2) begin
          n_fail++;
          $display("FAIL rd_spacing: idle cycles between reads %0d, required >=2 at %0t", rd_gap, $time);
        end
        rd_gap = 0;
      end else if (rd_gap < 100) begin
        rd_gap++;
      end
      if (ram_we != '0) begin
        n_assert++;
        if ($countones(ram_we) != 1) begin
          n_fail++;
          $display("FAIL we_onehot: ram_we %b, required one-hot at %0t", ram_we, $time);
        end
        e.bank = 0;
        for (int b = 0; b < NB; b++) if (ram_we[b]) e.bank = b;
        e.addr = ram_addr;
        e.data = ram_wdata;
        wlog.push_back(e);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    capture_len = PW'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else tick();
    end
    n_assert++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done not seen in %0d cycles, required done=1", tag, budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    n_assert++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, want 0", fifo_rd_en); end
    n_assert++; if (ram_we !== '0) begin n_fail++; $display("FAIL reset_ram_we: got %b, want 0", ram_we); end
    n_assert++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d, want 0", ram_addr); end
    n_assert++; if (ram_wdata !== '0) begin n_fail++; $display("FAIL reset_ram_wdata: got %h, want 0", ram_wdata); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, want 0", done); end
    n_assert++; if (samples_written !== '0) begin n_fail++; $display("FAIL reset_samples: got %0d, want 0", samples_written); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_prefill;
    int base;
    logic [DW-1:0] exp_d;
    base = wlog.size();
    for (int i = 0; i < 8; i++) begin
      exp_d = 16'h0100 + 16'(i);
      fq.push_back(exp_d);
    end
    repeat (2) tick();
    pulse_start(8);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prefill_busy: got %b, want 1", busy); end
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(100, "prefill");
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prefill_busy_at_done: got %b, want 0", busy); end
    tick();
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL prefill_done_pulse: got %b, want 0", done); end
    n_assert++; if (samples_written !== 16'd8) begin n_fail++; $display("FAIL prefill_samples: got %0d, want 8", samples_written); end
    n_assert++;
    if (wlog.size() - base != 8) begin
      n_fail++; $display("FAIL prefill_write_count: got %0d, want 8", wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_d = 16'h0100 + 16'(i);
        n_assert++;
        if (wlog[base+i].bank != 0 || wlog[base+i].addr != AW'(i) || wlog[base+i].data !== exp_d) begin
          n_fail++;
          $display("FAIL prefill_write%0d: got bank %0d addr %0d data %h, want bank 0 addr %0d data %h",
                   i, wlog[base+i].bank, wlog[base+i].addr, wlog[base+i].data, i, exp_d);
        end
      end
    end
  endtask

  task automatic test_zero_len;
    int base;
    base = wlog.size();
    pulse_start(0);
    n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, want 1", done); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b, want 0", busy); end
    tick();
    n_assert++; if (samples_written !== '0) begin n_fail++; $display("FAIL zero_samples: got %0d, want 0", samples_written); end
    n_assert++; if (wlog.size() != base) begin n_fail++; $display("FAIL zero_writes: got %0d, want 0", wlog.size() - base); end
  endtask

  task automatic test_stall;
    int base;
    logic [DW-1:0] exp_d;
    base = wlog.size();
    pulse_start(4);
    repeat (8) tick();
    n_assert++; if (wlog.size() != base) begin n_fail++; $display("FAIL stall_no_write: got %0d writes, want 0", wlog.size() - base); end
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b, want 1", busy); end
    capture_len = PW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h0200 + 16'(i);
      fq.push_back(exp_d);
      if (i < 3) repeat (10) tick();
    end
    wait_done(60, "stall");
    n_assert++; if (samples_written !== 16'd4) begin n_fail++; $display("FAIL stall_samples: got %0d, want 4", samples_written); end
    n_assert++;
    if (wlog.size() - base != 4) begin
      n_fail++; $display("FAIL stall_write_count: got %0d, want 4", wlog.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 16'h0200 + 16'(i);
        n_assert++;
        if (wlog[base+i].bank != 0 || wlog[base+i].addr != AW'(i) || wlog[base+i].data !== exp_d) begin
          n_fail++;
          $display("FAIL stall_write%0d: got addr %0d data %h, want addr %0d data %h",
                   i, wlog[base+i].addr, wlog[base+i].data, i, exp_d);
        end
      end
    end
    tick();
  endtask

  task automatic test_last_drain;
    int base;
    base = wlog.size();
    fq.push_back(16'h0600);
    tick();
    pulse_start(2);
    repeat (15) tick();
    n_assert++; if (wlog.size() - base != 1) begin n_fail++; $display("FAIL drain_one_write: got %0d writes, want 1", wlog.size() - base); end
    n_assert++; if (samples_written !== 16'd1) begin n_fail++; $display("FAIL drain_samples: got %0d, want 1", samples_written); end
    fq.push_back(16'h0601);
    wait_done(40, "drain");
    n_assert++;
    if (wlog.size() - base != 2) begin
      n_fail++; $display("FAIL drain_write_count: got %0d, want 2", wlog.size() - base);
    end else if (wlog[base+1].addr != AW'(1) || wlog[base+1].data !== 16'h0601) begin
      n_fail++; $display("FAIL drain_second_write: got addr %0d data %h, want addr 1 data 0601",
                         wlog[base+1].addr, wlog[base+1].data);
    end
    tick();
  endtask

  task automatic test_bank_cross;
    int base;
    int bad;
    int bank_e;
    base = wlog.size();
    bad = 0;
    auto_val = '0;
    auto_feed = 1'b1;
    pulse_start(16386);
    wait_done(16386 * 3 + 200, "bank");
    n_assert++; if (samples_written !== 16'd16386) begin n_fail++; $display("FAIL bank_samples: got %0d, want 16386", samples_written); end
    auto_feed = 1'b0;
    tick();
    fq.delete();
    n_assert++;
    if (wlog.size() - base != 16386) begin
      n_fail++; $display("FAIL bank_write_count: got %0d, want 16386", wlog.size() - base);
    end else begin
      for (int i = 0; i < 16386; i++) begin
        bank_e = i >> AW;
        if (wlog[base+i].bank != bank_e || wlog[base+i].addr != AW'(i) || wlog[base+i].data !== DW'(i)) bad++;
      end
      n_assert++; if (bad != 0) begin n_fail++; $display("FAIL bank_sequence: %0d mismatching writes, want 0", bad); end
      n_assert++;
      if (wlog[base+16383].bank != 0 || wlog[base+16383].addr != AW'(16383)) begin
        n_fail++; $display("FAIL bank_last_b0: got bank %0d addr %0d, want bank 0 addr 16383",
                           wlog[base+16383].bank, wlog[base+16383].addr);
      end
      n_assert++;
      if (wlog[base+16384].bank != 1 || wlog[base+16384].addr != AW'(0)) begin
        n_fail++; $display("FAIL bank_first_b1: got bank %0d addr %0d, want bank 1 addr 0",
                           wlog[base+16384].bank, wlog[base+16384].addr);
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit seen;
    base = wlog.size();
    fq.push_back(16'h0300);
    fq.push_back(16'h0301);
    tick();
    pulse_start(4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fifo_rd_en === 1'b1) seen = 1'b1;
      else tick();
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL rstmid_rd_timeout: rd_en not seen, want 1"); end
    tick();
    reset = 1'b1;
    tick();
    n_assert++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b, want 0", fifo_rd_en); end
    n_assert++; if (ram_we !== '0) begin n_fail++; $display("FAIL rstmid_ram_we: got %b, want 0", ram_we); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, want 0", busy); end
    n_assert++; if (samples_written !== '0) begin n_fail++; $display("FAIL rstmid_samples: got %0d, want 0", samples_written); end
    n_assert++; if (ram_wdata !== '0 || ram_addr !== '0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got wdata %h addr %0d done %b, want 0 0 0", ram_wdata, ram_addr, done);
    end
    n_assert++; if (wlog.size() != base) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes, want 0", wlog.size() - base); end
    reset = 1'b0;
    tick();
    fq.delete();
    fq.push_back(16'h0400);
    fq.push_back(16'h0401);
    tick();
    pulse_start(2);
    wait_done(40, "rstmid");
    n_assert++;
    if (wlog.size() - base != 2) begin
      n_fail++; $display("FAIL rstmid_write_count: got %0d, want 2", wlog.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (wlog[base+i].bank != 0 || wlog[base+i].addr != AW'(i) || wlog[base+i].data !== (16'h0400 + 16'(i))) begin
          n_fail++; $display("FAIL rstmid_write%0d: got bank %0d addr %0d data %h, want bank 0 addr %0d data %h",
                             i, wlog[base+i].bank, wlog[base+i].addr, wlog[base+i].data, i, 16'h0400 + 16'(i));
        end
      end
    end
    tick();
  endtask

`ifdef RAM_WR_WRAP_EN
  task automatic test_wrap;
    int base;
    bit seen;
    logic [AW-1:0] exp_a [6];
    exp_a = '{14'd0, 14'd1, 14'd2, 14'd3, 14'd0, 14'd1};
    base = wlog.size();
    for (int i = 0; i < 10; i++) fq.push_back(16'h0500 + 16'(i));
    tick();
    pulse_start(4);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (wlog.size() - base >= 6) seen = 1'b1;
      else tick();
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL wrap_sixth_timeout: got %0d writes, want 6", wlog.size() - base); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b, want 1", done); end
    n_assert++; if (samples_written !== 16'd4) begin n_fail++; $display("FAIL wrap_samples: got %0d, want 4", samples_written); end
    n_assert++;
    if (wlog.size() - base != 6) begin
      n_fail++; $display("FAIL wrap_write_count: got %0d, want 6", wlog.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_assert++;
        if (wlog[base+i].addr != exp_a[i] || wlog[base+i].data !== (16'h0500 + 16'(i))) begin
          n_fail++; $display("FAIL wrap_write%0d: got addr %0d data %h, want addr %0d data %h",
                             i, wlog[base+i].addr, wlog[base+i].data, exp_a[i], 16'h0500 + 16'(i));
        end
      end
    end
    tick();
    fq.delete();
  endtask
`endif

  initial begin
    test_reset();
`ifdef RAM_WR_WRAP_EN
    test_wrap();
`else
    test_prefill();
    test_zero_len();
    test_stall();
    test_last_drain();
    test_reset_mid();
    test_bank_cross();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
